mem_port_arbiter: RTL

Sequencer that shares the single-ported unified memory between the instruction-fetch path and the load/store path of the core. It accepts level-held requests from both sides, picks one round-robin, runs a fixed-latency memory transaction, and returns data with a one-cycle valid pulse. A `stall` output lets the program counter and datapath hold while either requester is waiting.

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer that shares one single-ported memory between the fetch
// path and the load/store path, one fixed-latency transaction at a time.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   output logic                    if_valid,
   input  logic                    ls_req,
   input  logic                    ls_we,
   input  logic [ADDR_WIDTH-1:0]   ls_addr,
   input  logic [DATA_WIDTH-1:0]   ls_wdata,
   input  logic [DATA_WIDTH/8-1:0] ls_be,
   output logic [DATA_WIDTH-1:0]   ls_rdata,
   output logic                    ls_valid,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    stall
);

   localparam int BE_WIDTH  = DATA_WIDTH / 8;
   localparam int CNT_WIDTH = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_WIDTH-1:0] LAT_CNT = CNT_WIDTH'(MEM_LATENCY);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                 state_r;
   state_t                 next_s;
   logic                   grant_ls_s;
   logic                   issue_s;
   logic                   resp_s;
   logic                   pay_we_s;
   logic [ADDR_WIDTH-1:0]  pay_addr_s;
   logic [DATA_WIDTH-1:0]  pay_wdata_s;
   logic [BE_WIDTH-1:0]    pay_be_s;
   logic                   last_ls_r;
   logic                   grant_ls_r;
   logic                   we_r;
   logic [CNT_WIDTH-1:0]   cnt_r;

   // Next-state decode and round-robin pick (ties go to the side not served last)
   always_comb begin
      next_s     = state_r;
      grant_ls_s = 1'b0;
      case (state_r)
         IDLE: begin
            grant_ls_s = ls_req & (~if_req | ~last_ls_r);
            if (if_req || ls_req) begin
               next_s = ISSUE;
            end else begin
               next_s = IDLE;
            end
         end
         ISSUE: next_s = WAIT;
         WAIT: begin
            if (cnt_r == LAT_CNT) begin
               next_s = RESP;
            end else begin
               next_s = WAIT;
            end
         end
         RESP:    next_s = IDLE;
         default: next_s = IDLE;
      endcase
      issue_s = (next_s == ISSUE);
      resp_s  = (next_s == RESP);
   end

   // Payload of the requester being granted this cycle; fetch never writes
   always_comb begin
      pay_we_s    = 1'b0;
      pay_addr_s  = if_addr;
      pay_wdata_s = '0;
      pay_be_s    = '0;
      if (grant_ls_s) begin
         pay_we_s    = ls_we;
         pay_addr_s  = ls_addr;
         pay_wdata_s = ls_wdata;
         pay_be_s    = ls_be;
      end else begin
         pay_we_s    = 1'b0;
         pay_addr_s  = if_addr;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Grant bookkeeping and latency counter
   always_ff @(posedge clk) begin
      if (rst) begin
         last_ls_r  <= 1'b0;
         grant_ls_r <= 1'b0;
         we_r       <= 1'b0;
         cnt_r      <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (issue_s) begin
                  grant_ls_r <= grant_ls_s;
                  last_ls_r  <= grant_ls_s;
                  we_r       <= pay_we_s;
               end
            end
            ISSUE: cnt_r <= CNT_WIDTH'(1);
            WAIT: begin
               if (cnt_r != LAT_CNT) begin
                  cnt_r <= cnt_r + CNT_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Registered outputs: the command is latched at the grant edge and held only
   // for ISSUE; read data is captured into the response registers leaving WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         if_valid  <= 1'b0;
         ls_valid  <= 1'b0;
         if_rdata  <= '0;
         ls_rdata  <= '0;
      end else begin
         mem_en    <= issue_s;
         mem_we    <= issue_s & pay_we_s;
         mem_addr  <= issue_s ? pay_addr_s : '0;
         mem_wdata <= issue_s ? pay_wdata_s : '0;
         mem_be    <= issue_s ? pay_be_s : '0;
         if_valid  <= resp_s & ~grant_ls_r;
         ls_valid  <= resp_s & grant_ls_r;
         if_rdata  <= (resp_s && !grant_ls_r && !we_r) ? mem_rdata : '0;
         ls_rdata  <= (resp_s && grant_ls_r && !we_r) ? mem_rdata : '0;
      end
   end

   assign stall = (if_req & ~if_valid) | (ls_req & ~ls_valid);

endmodule
